// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller and its prefetch buffer.
package ifetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_MEM_SIZE = 32'h0000_0800;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // A fetch address is usable when it is word aligned and inside instruction memory.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] mem_size);
    return (addr < mem_size) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, instr}, with push, pop, flush and occupancy count.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: storage is deliberately left unreset; pointers and count define validity, so stale words are never observed.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are log2(DEPTH) bits wide, so natural overflow wraps modulo DEPTH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: sequential fetch into a prefetch buffer with redirect and stall.
// Define IFETCH_BOUND_CHECK_EN to fault and halt on out-of-range or misaligned fetch addresses.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_req,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t         state;
  logic [31:0]    fetch_pc;
  logic           fault_q;
  logic           push;
  logic           pop;
  logic           flush;
  logic           full;
  logic           has_entry;
  logic           bad_addr;
  logic           bad_target;
  logic           target_legal;
  logic [CW-1:0]  count;
  fetch_entry_t   head;
  fetch_entry_t   push_data;

  assign target_legal = addr_legal(redirect_pc, MEM_SIZE);

`ifdef IFETCH_BOUND_CHECK_EN
  assign bad_addr   = (state == ST_RUN) && !redirect_valid && !addr_legal(fetch_pc, MEM_SIZE);
  assign bad_target = (state == ST_HALT) && !target_legal;
`else
  assign bad_addr   = 1'b0;
  assign bad_target = 1'b0;
`endif

  assign has_entry = (count != '0);
  assign if_valid  = has_entry && !redirect_valid;
  assign pop       = if_valid && if_ready;
  // A pop in the same cycle frees a slot, so a full buffer can still accept a push.
  assign push      = (state == ST_RUN) && !redirect_valid && !stall_req && !bad_addr && (!full || pop);
  assign flush     = redirect_valid && (state != ST_BOOT);
  assign push_data = '{pc: fetch_pc, instr: imem_data};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
      fault_q  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      fault_q  <= bad_target;
      state    <= (state == ST_HALT && !target_legal) ? ST_HALT : ST_RUN;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (bad_addr) begin
            state   <= ST_HALT;
            fault_q <= 1'b1;
          end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  assign imem_addr   = fetch_pc;
  assign if_pc       = has_entry ? head.pc    : '0;
  assign if_instr    = has_entry ? head.instr : '0;
  assign fetch_fault = fault_q;

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter MEM_SIZE, default 32'h0800, instruction-memory size in bytes.
REQ-003 Parameter DEPTH, default 2, prefetch buffer entries (power of two, >=2).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  32  byte address to instruction memory (combinational read, data valid same cycle).
REQ-007 imem_data  input  32  instruction word returned for imem_addr.
REQ-008 if_valid  output  1  head buffer entry valid toward decode.
REQ-009 if_ready  input  1  decode accepts head entry when if_valid && if_ready.
REQ-010 if_instr  output  32  instruction of head entry.
REQ-011 if_pc  output  32  byte address of head entry.
REQ-012 redirect_valid  input  1  branch/jump/exception redirect, one-cycle pulse.
REQ-013 redirect_pc  input  32  target of redirect.
REQ-014 stall_req  input  1  level; blocks new fetches while high.
REQ-015 fetch_fault  output  1  sticky fault flag (bad fetch address).

Function
REQ-016 FSM states: BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle; RUN -> HALT on fault; HALT -> RUN only on redirect_valid with legal redirect_pc.
REQ-017 imem_addr SHALL equal internal fetch_pc at all times.
REQ-018 Push in RUN when !redirect_valid && !stall_req && (count < DEPTH || pop); pushed entry = {imem_data, fetch_pc}; fetch_pc += 4 on push (mod 2^32).
REQ-019 Pop when if_valid && if_ready; head advances, count decrements.
REQ-020 Simultaneous push and pop at full SHALL be accepted; count unchanged.
REQ-021 if_valid = (count != 0) && !redirect_valid; no pop in a redirect cycle.
REQ-022 redirect_valid (any state except BOOT) SHALL clear buffer (count=0, pointers reset) and load fetch_pc=redirect_pc on the same edge; first push of target occurs next cycle.
REQ-023 redirect in BOOT SHALL be honoured (fetch_pc loaded) and BOOT still exits to RUN.
REQ-024 stall_req SHALL hold fetch_pc; buffer continues draining; redirect overrides stall.
REQ-025 Fetch-to-if_valid latency: one cycle from push edge when buffer empty.
REQ-026 In HALT no push; buffer drains normally; fetch_pc held.
REQ-027 Pointers wrap modulo DEPTH; count range 0..DEPTH.

Reset
REQ-028 On reset_n low: state=BOOT, fetch_pc=RESET_PC, count=0, pointers=0, fetch_fault=0, if_valid=0, if_instr=0, if_pc=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously).

Configuration
REQ-030 Macro IFETCH_BOUND_CHECK_EN: when defined, fetch_pc >= MEM_SIZE or fetch_pc[1:0] != 0 in RUN blocks the push, sets fetch_fault, enters HALT; redirect clears fetch_fault.
REQ-031 Without IFETCH_BOUND_CHECK_EN: no checks, fetch_fault tied 0, HALT unreachable, addresses issued unchanged.

Structure
REQ-032 Shared package holds state encoding (BOOT/RUN/HALT), instruction width 32, default RESET_PC and MEM_SIZE constants.
REQ-033 Prefetch buffer SHALL be sub-module ifetch_fifo (DEPTH x 64-bit {pc,instr}, push/pop/flush/count).

Verification
REQ-034 Reset release, if_ready=1, memory word n = n -> if_pc 0,4,8... consecutive cycles from cycle 2, if_instr 0,1,2...
REQ-035 if_ready=0 for 5 cycles -> count saturates at 2, fetch_pc=8, no overwrite; if_ready=1 -> entries 0,4 then 8 in order.
REQ-036 redirect_valid with redirect_pc=0x100 while buffer full -> if_valid=0 that cycle, next valid entry if_pc=0x100.
REQ-037 stall_req high 3 cycles -> fetch_pc frozen, buffer drains to empty, resume without gap or duplicate.
REQ-038 With IFETCH_BOUND_CHECK_EN, redirect to 0x0800 -> fetch_fault=1, HALT, no push; redirect to 0x10 -> fault cleared, fetch resumes at 0x10.
REQ-039 reset_n low with 2 entries buffered -> if_valid=0 immediately, restart at RESET_PC.
